mips_boot_ctrl: RTL and testbench

Boot and run sequencer for the two-stage-clocked MIPS core. It streams a program into instruction memory and initialises the register bank. It then releases the core from PC 0, waits for HLT, and streams the register bank out. Bench-time hierarchical pokes into `mem`, `reg_bank`, `PC`, `HALTED` and `TAKEN_BRANCH` are replaced by this block; it sits between a host stream interface and the core's memory and register-file ports.

---
 rtl/mips_pkg.sv | 18 +
 rtl/mips_boot_ctrl_if.sv | 40 ++++
 rtl/mips_boot_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mips_boot_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot/run sequencer and anything that models the core.
package mips_pkg;

   localparam int         NUM_REGS   = 32;
   localparam int         WORD_W     = 32;
   localparam logic [5:0] HLT_OPCODE = 6'b111111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RINIT,
      ST_CLEAR,
      ST_RUN,
      ST_DUMP,
      ST_DONE
   } boot_state_t;

endpackage

// File: rtl/mips_boot_ctrl_if.sv
// Host streams plus core memory / register-file ports of the boot sequencer.
interface mips_boot_ctrl_if #(
   parameter int ADDR_W = 10
);
   import mips_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;

   logic              rf_we;
   logic [4:0]        rf_addr;
   logic [WORD_W-1:0] rf_wdata;
   logic [4:0]        rf_raddr;
   logic [WORD_W-1:0] rf_rdata;

   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;
   logic              out_last;

   modport master (
      input  in_valid, in_data, rf_rdata, out_ready,
      output in_ready, mem_we, mem_addr, mem_wdata,
             rf_we, rf_addr, rf_wdata, rf_raddr,
             out_valid, out_data, out_last
   );

   modport slave (
      output in_valid, in_data, rf_rdata, out_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata,
             rf_we, rf_addr, rf_wdata, rf_raddr,
             out_valid, out_data, out_last
   );

endinterface

// File: rtl/mips_boot_ctrl.sv
// Loads a program, initialises the register bank, runs the core until HLT or
// timeout, then streams the register bank back to the host.
module mips_boot_ctrl
   import mips_pkg::*;
#(
   parameter int ADDR_W         = 10,
   parameter int DUMP_CNT       = 32,
   parameter int REG_INIT_INDEX = 1,
   parameter int MAX_CYCLES     = 4096
)(
   input  logic              clk1,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   prog_len,
   mips_boot_ctrl_if.master  bus,
   output logic              core_hold,
   output logic              core_clr,
   input  logic              core_halted,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [31:0]       run_cycles
);

   localparam int          LCW       = ADDR_W + 1;
   localparam logic [5:0]  LAST_IDX  = 6'(DUMP_CNT - 1);
   localparam logic [5:0]  LAST_REG  = 6'(NUM_REGS - 1);
   localparam logic [31:0] RUN_LIMIT = 32'(MAX_CYCLES - 1);

   boot_state_t     state_q, state_d;
   logic [5:0]      idx_q, idx_d;
   logic [LCW-1:0]  prog_len_q, prog_len_d;
   logic            timeout_q, timeout_d;
   logic [31:0]     run_cycles_q, run_cycles_d;

   logic            start_ok;
   logic            in_hs;
   logic            load_last;
   logic [LCW-1:0]  load_cnt;

   assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign in_hs     = (state_q == ST_LOAD) && bus.in_valid;
   assign load_last = in_hs && ((load_cnt + LCW'(1)) == prog_len_q);

   // The 6-bit index can only address the program when memory is tiny.
   generate
      if (ADDR_W > 5) begin : g_wide_load
         logic [LCW-1:0] load_cnt_q, load_cnt_d;

         always_comb begin
            load_cnt_d = load_cnt_q;
            if (start_ok) begin
               load_cnt_d = '0;
            end else if (in_hs) begin
               load_cnt_d = load_cnt_q + LCW'(1);
            end
         end

         always_ff @(posedge clk1 or posedge rst) begin
            if (rst) begin
               load_cnt_q <= '0;
            end else begin
               load_cnt_q <= load_cnt_d;
            end
         end

         assign load_cnt = load_cnt_q;
      end else begin : g_shared_load
         assign load_cnt = LCW'(idx_q);
      end
   endgenerate

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      prog_len_d    = prog_len_q;
      timeout_d     = timeout_q;
      run_cycles_d  = run_cycles_q;
      bus.in_ready  = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.rf_we     = 1'b0;
      bus.rf_addr   = '0;
      bus.rf_wdata  = '0;
      bus.rf_raddr  = '0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_last  = 1'b0;
      core_hold     = 1'b1;
      core_clr      = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               prog_len_d   = prog_len;
               timeout_d    = 1'b0;
               run_cycles_d = '0;
               idx_d        = '0;
               state_d      = (prog_len != '0) ? ST_LOAD : ST_RINIT;
            end
         end
         ST_LOAD: begin
            bus.in_ready  = 1'b1;
            bus.mem_we    = bus.in_valid;
            bus.mem_addr  = load_cnt[ADDR_W-1:0];
            bus.mem_wdata = bus.in_data;
            if (load_last) begin
               idx_d   = '0;
               state_d = ST_RINIT;
            end else if (in_hs) begin
               idx_d = idx_q + 6'd1;
            end
         end
         ST_RINIT: begin
            bus.rf_we    = 1'b1;
            bus.rf_addr  = idx_q[4:0];
            bus.rf_wdata = (REG_INIT_INDEX != 0) ? {26'b0, idx_q} : '0;
            if (idx_q == LAST_REG) begin
               idx_d   = '0;
               state_d = ST_CLEAR;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         ST_CLEAR: begin
            core_clr = 1'b1;
            state_d  = ST_RUN;
         end
         ST_RUN: begin
            core_hold = 1'b0;
            if (core_halted) begin
               idx_d   = '0;
               state_d = ST_DUMP;
            end else begin
               if (run_cycles_q != '1) begin
                  run_cycles_d = run_cycles_q + 32'd1;
               end
               if (run_cycles_d >= RUN_LIMIT) begin
                  timeout_d = 1'b1;
                  idx_d     = '0;
                  state_d   = ST_DUMP;
               end
            end
         end
         ST_DUMP: begin
            bus.rf_raddr  = idx_q[4:0];
            bus.out_valid = 1'b1;
            bus.out_data  = bus.rf_rdata;
            bus.out_last  = (idx_q == LAST_IDX);
            if (bus.out_ready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         prog_len_q   <= '0;
         timeout_q    <= 1'b0;
         run_cycles_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         prog_len_q   <= prog_len_d;
         timeout_q    <= timeout_d;
         run_cycles_q <= run_cycles_d;
      end
   end

   assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done       = (state_q == ST_DONE);
   assign timeout    = timeout_q;
   assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Bench for mips_boot_ctrl: a small behavioural MIPS core executes the loaded
// program; writes and dump words are checked against queued expectations.
module tb_mips_boot_ctrl;
   import mips_pkg::*;

   localparam int ADDR_W     = 10;
   localparam int DUMP_CNT   = 6;
   localparam int MAX_CYCLES = 16;

   logic              clk1 = 1'b0;
   logic              rst  = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W:0]   prog_len = '0;
   logic              core_hold, core_clr, core_halted;
   logic              busy, done, timeout;
   logic [31:0]       run_cycles;

   mips_boot_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   mips_boot_ctrl #(
      .ADDR_W(ADDR_W), .DUMP_CNT(DUMP_CNT), .REG_INIT_INDEX(1), .MAX_CYCLES(MAX_CYCLES)
   ) dut (
      .clk1(clk1), .rst(rst), .start(start), .prog_len(prog_len), .bus(bus),
      .core_hold(core_hold), .core_clr(core_clr), .core_halted(core_halted),
      .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles)
   );

   always #5 clk1 = ~clk1;

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          t0    = 0;
   logic [41:0] exp_mem[$];
   logic [32:0] exp_dump[$];
   logic [31:0] prog [9];

   always @(posedge clk1) cyc <= cyc + 1;

   // Behavioural core: one instruction per unheld cycle (ADD, OR, ADDI, HLT).
   logic [31:0] mem [1024] = '{default: 32'h0};
   logic [31:0] rb  [32]   = '{default: 32'h0};
   logic [9:0]  pc      = '0;
   logic        halted  = 1'b0;
   logic        no_halt = 1'b0;
   logic [31:0] ir;

   assign ir           = mem[pc];
   assign core_halted  = halted;
   assign bus.rf_rdata = rb[bus.rf_raddr];

   always @(posedge clk1) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.rf_we)  rb[bus.rf_addr]   <= bus.rf_wdata;
      if (core_clr) begin
         pc     <= '0;
         halted <= 1'b0;
      end else if (!core_hold && !halted) begin
         case (ir[31:26])
            6'b000000:  rb[ir[15:11]] <= rb[ir[25:21]] + rb[ir[20:16]];
            6'b000011:  rb[ir[15:11]] <= rb[ir[25:21]] | rb[ir[20:16]];
            6'b001010:  rb[ir[20:16]] <= rb[ir[25:21]] + {{16{ir[15]}}, ir[15:0]};
            HLT_OPCODE: if (!no_halt) halted <= 1'b1;
            default: ;
         endcase
         pc <= pc + 10'd1;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end else begin
         $display("ok   %s: %h", name, got);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT writes memory or hands over a dump word.
   always @(negedge clk1) begin
      if (!rst) begin
         if (bus.mem_we) begin
            if (exp_mem.size() == 0) begin
               check("mem_unexpected", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
               logic [41:0] e;
               e = exp_mem.pop_front();
               check("mem_addr", 32'(bus.mem_addr), 32'(e[41:32]));
               check("mem_data", bus.mem_wdata, e[31:0]);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_dump.size() == 0) begin
               check("dump_unexpected", bus.out_data, 32'hFFFF_FFFF);
            end else begin
               logic [32:0] e;
               e = exp_dump.pop_front();
               check("dump_data", bus.out_data, e[31:0]);
               check("dump_last", 32'(bus.out_last), 32'(e[32]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic push_dump(input logic [31:0] r1, input logic [31:0] r4, input logic [31:0] r5);
      exp_dump.push_back({1'b0, 32'd0});
      exp_dump.push_back({1'b0, r1});
      exp_dump.push_back({1'b0, 32'd20});
      exp_dump.push_back({1'b0, 32'd25});
      exp_dump.push_back({1'b0, r4});
      exp_dump.push_back({1'b1, r5});
   endtask

   task automatic start_seq(input int n, input bit toggle);
      start    = 1'b1;
      prog_len = (ADDR_W+1)'(n);
      tick();
      t0    = cyc;
      start = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      for (int i = 0; i < n; i++) begin
         if (toggle && i > 0) begin
            bus.in_valid = 1'b0;
            tick();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = prog[i];
         exp_mem.push_back({10'(i), prog[i]});
         tick();
      end
      bus.in_valid = 1'b0;
      if (n > 0) check("rinit_after_load", {26'd0, bus.rf_we, bus.rf_addr}, {26'd0, 1'b1, 5'd0});
   endtask

   task automatic wait_unheld(input int n, input bit check_timing);
      int k = 0;
      while (core_hold && k < 300) begin
         tick();
         k++;
      end
      check("reached_run", 32'(core_hold), 32'd0);
      if (check_timing) check("first_unheld_cycle", 32'(cyc + 1 - t0), 32'(n + 34));
   endtask

   task automatic wait_done(input bit exp_to, input logic [31:0] exp_rc);
      int k = 0;
      while (!done && k < 300) begin
         tick();
         k++;
      end
      check("done", 32'(done), 32'd1);
      check("timeout", 32'(timeout), 32'(exp_to));
      check("run_cycles", run_cycles, exp_rc);
      check("done_hold", 32'(core_hold), 32'd1);
      check("scoreboard_drained", 32'(exp_mem.size() + exp_dump.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      prog = '{32'h2801000A, 32'h28020014, 32'h28030019, 32'h0CE77800, 32'h0CE77800,
               32'h00222000, 32'h0CE77800, 32'h00832800, 32'hFC000000};

      // Reset state
      repeat (2) tick();
      check("rst_hold", 32'(core_hold), 32'd1);
      check("rst_status", {28'd0, busy, done, timeout, core_clr}, 32'd0);
      check("rst_run_cycles", run_cycles, 32'd0);
      check("rst_we", {28'd0, bus.mem_we, bus.rf_we, bus.out_valid, bus.in_ready}, 32'd0);
      rst = 1'b0;
      tick();

      // Full program, back-to-back load, halts after 9 run cycles
      push_dump(32'd10, 32'd30, 32'd55);
      start_seq(9, 1'b0);
      wait_unheld(9, 1'b1);
      wait_done(1'b0, 32'd9);

      // Core that never halts: budget expires
      no_halt = 1'b1;
      push_dump(32'd10, 32'd30, 32'd55);
      start_seq(0, 1'b0);
      wait_unheld(0, 1'b1);
      wait_done(1'b1, 32'd15);
      no_halt = 1'b0;

      // Output back-pressure on word 2
      push_dump(32'd10, 32'd30, 32'd55);
      start_seq(0, 1'b0);
      wait_unheld(0, 1'b1);
      begin
         int k = 0;
         while (!(bus.out_valid && bus.rf_raddr == 5'd1) && k < 100) begin
            tick();
            k++;
         end
      end
      check("reached_dump_word1", 32'(bus.rf_raddr), 32'd1);
      tick();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk1);
         check("stall_data", bus.out_data, 32'd20);
         check("stall_valid_idx", {26'd0, bus.out_valid, bus.rf_raddr}, {26'd0, 1'b1, 5'd2});
         tick();
      end
      bus.out_ready = 1'b1;
      wait_done(1'b0, 32'd9);

      // Empty load, start pulsed during RUN must be ignored
      push_dump(32'd10, 32'd30, 32'd55);
      start_seq(0, 1'b0);
      wait_unheld(0, 1'b1);
      start    = 1'b1;
      prog_len = '0;
      tick();
      start = 1'b0;
      check("start_ignored_run", {30'd0, core_hold, bus.rf_we}, 32'd0);
      check("start_ignored_busy", 32'(busy), 32'd1);
      wait_done(1'b0, 32'd9);

      // Asynchronous reset in the middle of register initialisation
      start_seq(0, 1'b0);
      begin
         int k = 0;
         while (!(bus.rf_we && bus.rf_addr == 5'd10) && k < 100) begin
            tick();
            k++;
         end
      end
      check("reached_rinit_10", 32'(bus.rf_addr), 32'd10);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_rf_we", 32'(bus.rf_we), 32'd0);
      check("rst_mid_hold", 32'(core_hold), 32'd1);
      check("rst_mid_idle", {30'd0, busy, done}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Gapped 4-word load from IDLE with a modified first instruction
      prog[0] = 32'h2801000B;
      push_dump(32'd11, 32'd31, 32'd56);
      start_seq(4, 1'b1);
      wait_unheld(4, 1'b0);
      wait_done(1'b0, 32'd9);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
